event_timestamper: RTL and testbench

- Measures the cycle latency of tagged transactions. A "start" event for an ID records a timestamp from a free-running counter. A matching "end" event for that ID produces one result record: ID, start timestamp, end timestamp and delta.
- Sits between event sources (e.g. packet ingress/egress hooks) and a downstream logger or statistics consumer.
- All three interfaces use valid/ready handshakes.

---
 rtl/event_timestamper.sv | 92 +++++++++
 tb/tb_event_timestamper.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/event_timestamper.sv
// rtl/event_timestamper.sv - per-ID start/end cycle latency measurement with valid/ready result output
module event_timestamper #(
    parameter int ID_W = 3,
    parameter int TS_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [ID_W-1:0] start_id,
    input  logic            end_valid,
    output logic            end_ready,
    input  logic [ID_W-1:0] end_id,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ID_W-1:0] out_id,
    output logic [TS_W-1:0] out_start_ts,
    output logic [TS_W-1:0] out_end_ts,
    output logic [TS_W-1:0] out_delta
);

    localparam int N = 1 << ID_W;

    logic [TS_W-1:0] cnt_q;
    logic [N-1:0]    active_q;
    logic [N-1:0]    active_d;
    logic [TS_W-1:0] start_ts_q [N];

    logic start_fire;
    logic end_fire;
    logic end_hit;

    assign end_ready   = !out_valid || out_ready;
    assign end_fire    = end_valid && end_ready;
    assign end_hit     = end_fire && active_q[end_id];
    // An end for the same ID this cycle blocks the start, so an ID never
    // closes and reopens on one edge.
    assign start_ready = !active_q[start_id] && !(end_fire && (end_id == start_id));
    assign start_fire  = start_valid && start_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + TS_W'(1);
        end
    end

    always_comb begin
        active_d = active_q;
        if (end_hit) begin
            active_d[end_id] = 1'b0;
        end
        if (start_fire) begin
            active_d[start_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= '0;
        end else begin
            active_q <= active_d;
        end
    end

    // Timestamps carry no reset; they are only read while the ID is active.
    always_ff @(posedge clk) begin
        if (start_fire && !rst) begin
            start_ts_q[start_id] <= cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_id       <= '0;
            out_start_ts <= '0;
            out_end_ts   <= '0;
            out_delta    <= '0;
        end else if (end_hit) begin
            out_valid    <= 1'b1;
            out_id       <= end_id;
            out_start_ts <= start_ts_q[end_id];
            out_end_ts   <= cnt_q;
            out_delta    <= cnt_q - start_ts_q[end_id];
        end else begin
            out_valid    <= out_valid && !out_ready;
        end
    end

endmodule

// File: tb/tb_event_timestamper.sv
// tb/tb_event_timestamper.sv - scoreboard bench for event_timestamper with directed vectors
module tb_event_timestamper;

    localparam int ID_W = 3;
    localparam int TS_W = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start_valid = 1'b0;
    logic            start_ready;
    logic [ID_W-1:0] start_id = '0;
    logic            end_valid = 1'b0;
    logic            end_ready;
    logic [ID_W-1:0] end_id = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [ID_W-1:0] out_id;
    logic [TS_W-1:0] out_start_ts;
    logic [TS_W-1:0] out_end_ts;
    logic [TS_W-1:0] out_delta;

    event_timestamper #(.ID_W(ID_W), .TS_W(TS_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .start_id     (start_id),
        .end_valid    (end_valid),
        .end_ready    (end_ready),
        .end_id       (end_id),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_id       (out_id),
        .out_start_ts (out_start_ts),
        .out_end_ts   (out_end_ts),
        .out_delta    (out_delta)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [TS_W-1:0] s;
        logic [TS_W-1:0] e;
        logic [TS_W-1:0] d;
    } rec_t;

    rec_t exp_q [$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [TS_W-1:0] tb_cnt;

    // Bench-side time reference: the counter value the DUT should hold.
    always @(posedge clk or posedge rst) begin
        if (rst) tb_cnt <= '0;
        else     tb_cnt <= tb_cnt + 8'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_cnt(input logic [TS_W-1:0] v);
        int guard = 0;
        while (tb_cnt != v && guard < 600) begin
            tick();
            guard++;
        end
    endtask

    task automatic push(input int id, input int s, input int e, input int d);
        rec_t r;
        r.id = ID_W'(id);
        r.s  = TS_W'(s);
        r.e  = TS_W'(e);
        r.d  = TS_W'(d);
        exp_q.push_back(r);
    endtask

    task automatic do_start(input int id);
        start_valid = 1'b1;
        start_id    = ID_W'(id);
        #1;
        check("start_ready", {31'd0, start_ready}, 32'd1);
        tick();
        start_valid = 1'b0;
    endtask

    task automatic do_end(input int id);
        end_valid = 1'b1;
        end_id    = ID_W'(id);
        #1;
        check("end_ready", {31'd0, end_ready}, 32'd1);
        tick();
        end_valid = 1'b0;
    endtask

    // Monitor: each negedge with valid && ready sees a record consumed on the next edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL out_unexpected: got id=%0d s=%0d e=%0d d=%0d required none",
                         out_id, out_start_ts, out_end_ts, out_delta);
            end else begin
                rec_t r;
                r = exp_q.pop_front();
                if (out_id !== r.id || out_start_ts !== r.s || out_end_ts !== r.e || out_delta !== r.d) begin
                    n_bad++;
                    $display("FAIL out_record: got id=%0d s=%0d e=%0d d=%0d required id=%0d s=%0d e=%0d d=%0d",
                             out_id, out_start_ts, out_end_ts, out_delta, r.id, r.s, r.e, r.d);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] snap;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_fields", {out_id, out_start_ts, out_end_ts, out_delta}, 32'd0);
        check("rst_start_ready", {31'd0, start_ready}, 32'd1);
        check("rst_end_ready", {31'd0, end_ready}, 32'd1);
        rst = 1'b0;

        // Basic
        at_cnt(5);  do_start(3);
        at_cnt(11); do_end(3); push(3, 5, 11, 6);
        check("basic_latency", {31'd0, out_valid}, 32'd1);

        // Out-of-order burst
        at_cnt(20); do_start(0);
        at_cnt(22); do_start(1);
        at_cnt(24); do_start(2);
        at_cnt(30); do_end(1); push(1, 22, 30, 8);
        at_cnt(32); do_end(0); push(0, 20, 32, 12);
        at_cnt(34); do_end(2); push(2, 24, 34, 10);

        // Same-ID collision: end wins, start follows one cycle later
        at_cnt(40); do_start(5);
        at_cnt(43);
        start_valid = 1'b1; start_id = 3'd5;
        end_valid   = 1'b1; end_id   = 3'd5;
        #1;
        check("coll_start_ready", {31'd0, start_ready}, 32'd0);
        check("coll_end_ready", {31'd0, end_ready}, 32'd1);
        tick();
        push(5, 40, 43, 3);
        end_valid = 1'b0;
        #1;
        check("coll_start_next", {31'd0, start_ready}, 32'd1);
        tick();
        start_valid = 1'b0;
        at_cnt(49); do_end(5); push(5, 44, 49, 5);

        // Counter wrap
        at_cnt(250); do_start(2);
        at_cnt(4);   do_end(2); push(2, 250, 4, 10);
        check("wrap_end_ts", {24'd0, out_end_ts}, 32'd4);
        check("wrap_delta", {24'd0, out_delta}, 32'd10);

        // Backpressure
        at_cnt(10); do_start(4);
        at_cnt(11); do_start(6);
        out_ready = 1'b0;
        at_cnt(20); do_end(4); push(4, 10, 20, 10);
        snap = {out_id, out_start_ts, out_end_ts, out_delta};
        end_valid = 1'b1; end_id = 3'd6;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_end_ready", {31'd0, end_ready}, 32'd0);
            check("bp_stable", {out_id, out_start_ts, out_end_ts, out_delta}, snap);
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'd0, end_ready}, 32'd1);
        tick();
        push(6, 11, 25, 14);
        end_valid = 1'b0;
        check("bp_second_valid", {31'd0, out_valid}, 32'd1);
        check("bp_second_id", {29'd0, out_id}, 32'd6);

        // Duplicate start stalls until the end for that ID
        at_cnt(30); do_start(1);
        start_valid = 1'b1; start_id = 3'd1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("dup_stall", {31'd0, start_ready}, 32'd0);
            tick();
        end
        end_valid = 1'b1; end_id = 3'd1;
        #1;
        check("dup_coll_ready", {31'd0, start_ready}, 32'd0);
        tick();
        push(1, 30, 35, 5);
        end_valid = 1'b0;
        #1;
        check("dup_accept", {31'd0, start_ready}, 32'd1);
        tick();
        start_valid = 1'b0;
        at_cnt(40); do_end(1); push(1, 36, 40, 4);

        // Stray end on an inactive ID
        at_cnt(45); do_end(7);
        check("stray_no_out", {31'd0, out_valid}, 32'd0);

        // Reset mid-operation discards the pending start
        at_cnt(50); do_start(0);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        rst = 1'b0;
        at_cnt(3); do_end(0);
        check("midrst_discard", {31'd0, out_valid}, 32'd0);

        repeat (3) tick();
        check("sb_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
